// File: rtl/led_blink_sequencer_if.sv
// Start/busy/done handshake and LED drive between an upstream controller and the blink sequencer.
// Ports: i_start/i_count come from the controller; o_busy/o_done/o_led are returned by the sequencer.
// Modports: master = controller side, slave = sequencer side.
interface led_blink_sequencer_if #(
    parameter int CNT_W = 4
);
    logic             i_start;
    logic [CNT_W-1:0] i_count;
    logic             o_busy;
    logic             o_done;
    logic             o_led;

    modport master (
        output i_start,
        output i_count,
        input  o_busy,
        input  o_done,
        input  o_led
    );

    modport slave (
        input  i_start,
        input  i_count,
        output o_busy,
        output o_done,
        output o_led
    );
endinterface

// File: rtl/led_blink_sequencer.sv
// Drives an LED through N timed on/off blinks on request, then pulses o_done for one cycle.
// Latency: outputs registered, o_led/o_busy (or o_done for a zero count) follow an accepted start by one cycle.
// Backpressure: starts are only accepted in IDLE; requests while busy or in DONE are dropped, not queued.
// Ports: clk, i_rst (sync, active-high), bus (slave modport: i_start, i_count, o_busy, o_done, o_led).
// Optional macro LED_PWM_EN: PWM-dims the LED during ON using PWM_PER/PWM_DUTY.
module led_blink_sequencer #(
    parameter int CLKS_ON  = 12_500_000,
    parameter int CLKS_OFF = 12_500_000,
    parameter int CNT_W    = 4,
    parameter int PWM_PER  = 16,
    parameter int PWM_DUTY = 4
) (
    input  logic                  clk,
    input  logic                  i_rst,
    led_blink_sequencer_if.slave  bus
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ON   = 2'd1;
    localparam logic [1:0] S_OFF  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam int TMAX = (CLKS_ON > CLKS_OFF) ? CLKS_ON : CLKS_OFF;
    localparam int TW   = $clog2(TMAX + 1);
    localparam logic [TW-1:0] ON_LAST  = TW'(CLKS_ON - 1);
    localparam logic [TW-1:0] OFF_LAST = TW'(CLKS_OFF - 1);

    logic [1:0]       state, state_nxt;
    logic [TW-1:0]    timer, timer_nxt;
    logic [CNT_W-1:0] rem, rem_nxt;
    logic             led_nxt;

    // Next-state logic; the phase timer restarts from zero on every state change.
    always_comb begin
        state_nxt = state;
        timer_nxt = timer;
        rem_nxt   = rem;
        case (state)
            S_IDLE: begin
                timer_nxt = '0;
                if (bus.i_start) begin
                    if (bus.i_count != '0) begin
                        state_nxt = S_ON;
                        rem_nxt   = bus.i_count;
                    end else begin
                        state_nxt = S_DONE;
                    end
                end
            end
            S_ON: begin
                if (timer == ON_LAST) begin
                    state_nxt = S_OFF;
                    timer_nxt = '0;
                end else begin
                    timer_nxt = timer + TW'(1);
                end
            end
            S_OFF: begin
                if (timer == OFF_LAST) begin
                    timer_nxt = '0;
                    rem_nxt   = rem - CNT_W'(1);
                    // rem still holds the blink just finished, so 1 means this was the last one.
                    state_nxt = (rem == CNT_W'(1)) ? S_DONE : S_ON;
                end else begin
                    timer_nxt = timer + TW'(1);
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
                timer_nxt = '0;
            end
            default: begin
                state_nxt = S_IDLE;
                timer_nxt = '0;
            end
        endcase
    end

`ifdef LED_PWM_EN
    localparam int PW = $clog2(PWM_PER);

    logic [PW-1:0] pwm_cnt, pwm_nxt;

    // Free-running PWM phase, forced back to zero on entry to ON so each blink starts high.
    always_comb begin
        if (state_nxt == S_ON && state != S_ON) begin
            pwm_nxt = '0;
        end else if (pwm_cnt == PW'(PWM_PER - 1)) begin
            pwm_nxt = '0;
        end else begin
            pwm_nxt = pwm_cnt + PW'(1);
        end
        led_nxt = (state_nxt == S_ON) && (int'(pwm_nxt) < PWM_DUTY);
    end

    always_ff @(posedge clk) begin
        if (i_rst) begin
            pwm_cnt <= '0;
        end else begin
            pwm_cnt <= pwm_nxt;
        end
    end
`else
    localparam int unused_pwm_cfg = PWM_PER + PWM_DUTY;

    always_comb begin
        led_nxt = (state_nxt == S_ON);
    end
`endif

    // Outputs are registered from the next state so they line up with the state register.
    always_ff @(posedge clk) begin
        if (i_rst) begin
            state      <= S_IDLE;
            timer      <= '0;
            rem        <= '0;
            bus.o_led  <= 1'b0;
            bus.o_busy <= 1'b0;
            bus.o_done <= 1'b0;
        end else begin
            state      <= state_nxt;
            timer      <= timer_nxt;
            rem        <= rem_nxt;
            bus.o_led  <= led_nxt;
            bus.o_busy <= (state_nxt == S_ON) || (state_nxt == S_OFF);
            bus.o_done <= (state_nxt == S_DONE);
        end
    end
endmodule

// File: tb/tb_led_blink_sequencer.sv
// Self-checking bench for led_blink_sequencer: directed scenarios followed by random start/count/reset traffic.
// A sequence-level reference model queues the expected {led,busy,done} per clock; a monitor pops and compares.
// Define LED_PWM_EN to exercise the PWM build (CLKS_ON=8, PWM_PER=4, PWM_DUTY=1).
module tb_led_blink_sequencer;
`ifdef LED_PWM_EN
    localparam int ON   = 8;
    localparam int PER  = 4;
    localparam int DUTY = 1;
`else
    localparam int ON   = 4;
    localparam int PER  = 16;
    localparam int DUTY = 4;
`endif
    localparam int OFF = 3;
    localparam int CW  = 4;

    logic clk;
    logic rst;
    int   cyc;
    int   vectors;
    int   miscompares;
    bit   armed;

    logic [2:0] exp_q[$];   // {led, busy, done} for each upcoming clock edge

    led_blink_sequencer_if #(.CNT_W(CW)) bus();

    led_blink_sequencer #(
        .CLKS_ON (ON),
        .CLKS_OFF(OFF),
        .CNT_W   (CW),
        .PWM_PER (PER),
        .PWM_DUTY(DUTY)
    ) dut (
        .clk  (clk),
        .i_rst(rst),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // LED level expected in cycle t of an ON phase.
    function automatic logic led_on(input int t);
`ifdef LED_PWM_EN
        return (t % PER) < DUTY;
`else
        return 1'b1;
`endif
    endfunction

    // Whole accepted request: N blinks, the done pulse, then the DONE cycle's ignored-start slot.
    task automatic push_request(input int n);
        for (int b = 0; b < n; b++) begin
            for (int t = 0; t < ON; t++) exp_q.push_back({led_on(t), 1'b1, 1'b0});
            for (int t = 0; t < OFF; t++) exp_q.push_back(3'b010);
        end
        exp_q.push_back(3'b001);
        exp_q.push_back(3'b000);
    endtask

    // Reference model: an empty queue means the previous request has fully played out (IDLE).
    task automatic model_step(input bit r, input bit s, input logic [CW-1:0] c);
        if (r) begin
            exp_q.delete();
            exp_q.push_back(3'b000);
        end else if (exp_q.size() == 0) begin
            if (s) push_request(int'(c));
            else   exp_q.push_back(3'b000);
        end
        armed = 1'b1;
    endtask

    task automatic drive(input bit r, input bit s, input logic [CW-1:0] c, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            rst         = r;
            bus.i_start = s;
            bus.i_count = c;
            model_step(r, s, c);
        end
    endtask

    // Monitor: one expected triple per clock edge, sampled just after the edge.
    always begin
        logic [2:0] act;
        logic [2:0] exp;
        @(posedge clk);
        #1;
        if (armed) begin
            act = {bus.o_led, bus.o_busy, bus.o_done};
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL scoreboard_empty cycle %0d: got led/busy/done=%b, no expected entry", cyc, act);
            end else begin
                exp = exp_q.pop_front();
                if (act !== exp) begin
                    miscompares++;
                    $display("FAIL outputs cycle %0d: got led/busy/done=%b required %b", cyc, act, exp);
                end
            end
        end
    end

    initial begin
        cyc         = 0;
        vectors     = 0;
        miscompares = 0;
        armed       = 1'b0;
        rst         = 1'b1;
        bus.i_start = 1'b0;
        bus.i_count = '0;

        // Reset and quiet idle.
        drive(1, 0, 4'd0, 2);
        drive(0, 0, 4'd0, 2);
        // Two blinks from a single-cycle start.
        drive(0, 1, 4'd2, 1);
        drive(0, 0, 4'd0, 17);
        // Zero-count request: done pulse only.
        drive(0, 1, 4'd0, 1);
        drive(0, 0, 4'd0, 3);
        // Start held high: back-to-back single blinks.
        drive(0, 1, 4'd1, 22);
        drive(0, 0, 4'd0, 10);
        // Re-request with a different count during a 3-blink run.
        drive(0, 1, 4'd3, 1);
        drive(0, 0, 4'd0, 4);
        drive(0, 1, 4'd5, 3);
        drive(0, 0, 4'd0, 20);
        // Reset in the second ON phase, then a normal start.
        drive(0, 1, 4'd3, 1);
        drive(0, 0, 4'd0, 8);
        drive(1, 1, 4'd3, 1);
        drive(0, 0, 4'd0, 5);
        drive(0, 1, 4'd1, 1);
        drive(0, 0, 4'd0, 12);
        // Maximum count.
        drive(0, 1, 4'd15, 1);
        drive(0, 0, 4'd0, 15 * (ON + OFF) + 4);

        // Random traffic, mostly short counts, occasional resets.
        for (int i = 0; i < 1500; i++) begin
            bit               r;
            bit               s;
            logic [CW-1:0]    c;
            r = ($urandom_range(0, 59) == 0);
            s = ($urandom_range(0, 3) == 0);
            c = ($urandom_range(0, 7) == 0) ? CW'($urandom_range(0, 15)) : CW'($urandom_range(0, 3));
            drive(r, s, c, 1);
        end

        // Let any in-flight request drain, bounded.
        begin
            int guard;
            guard = 0;
            while (exp_q.size() > 1 && guard < 2000) begin
                drive(0, 0, 4'd0, 1);
                guard++;
            end
            if (exp_q.size() > 1) begin
                vectors++;
                miscompares++;
                $display("FAIL drain_timeout: got %0d entries pending, required at most 1", exp_q.size());
            end
        end
        drive(0, 0, 4'd0, 3);
        @(posedge clk);
        #2;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
